// File: rtl/depuncturer_multirate_wifi_if.sv
// Bus bundle for the multirate 802.11 depuncturer: frame control,
// the serial soft-symbol input and the rebuilt (A,B) pair output.
interface depuncturer_multirate_wifi_if #(
  parameter int SOFT_W = 3,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [1:0]        rate;
  logic [LEN_W-1:0]  num_pairs;
  logic              valid_in;
  logic [SOFT_W-1:0] data_in;
  logic              valid_out;
  logic [SOFT_W-1:0] data_a;
  logic [SOFT_W-1:0] data_b;
  logic              erase_a;
  logic              erase_b;
  logic              busy;
  logic              finished;

  modport master (
    output start, rate, num_pairs, valid_in, data_in,
    input  valid_out, data_a, data_b, erase_a, erase_b, busy, finished
  );

  modport slave (
    input  start, rate, num_pairs, valid_in, data_in,
    output valid_out, data_a, data_b, erase_a, erase_b, busy, finished
  );
endinterface

// File: rtl/depuncturer_multirate_wifi.sv
// Run-time rate-selectable 802.11 depuncturer. Rebuilds (A,B) coded pairs
// from a serial stream of received soft symbols, filling punctured
// positions with zero and an erasure flag. One frame per start pulse.
module depuncturer_multirate_wifi #(
  parameter int SOFT_W = 3,
  parameter int LEN_W  = 16
) (
  input logic                         clk,
  input logic                         reset,
  input logic                         enable,
  depuncturer_multirate_wifi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rate_q, rate_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        phase_q, phase_d;
  logic [SOFT_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              valid_out_q, valid_out_d;
  logic [SOFT_W-1:0] data_a_q, data_a_d;
  logic [SOFT_W-1:0] data_b_q, data_b_d;
  logic              erase_a_q, erase_a_d;
  logic              erase_b_q, erase_b_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;

  logic              pres_a;
  logic              pres_b;
  logic [2:0]        period;
  logic [LEN_W-1:0]  cnt_inc;

  // Puncturing pattern lookup: which branches are transmitted in this phase.
  always_comb begin
    pres_a = 1'b1;
    pres_b = 1'b1;
    period = 3'd1;
    case (rate_q)
      2'b00: begin
        period = 3'd1;
      end
      2'b01: begin
        period = 3'd2;
        pres_b = (phase_q == 3'd0);
      end
      2'b10: begin
        period = 3'd3;
        pres_a = (phase_q != 3'd2);
        pres_b = (phase_q != 3'd1);
      end
      default: begin
        period = 3'd5;
        pres_a = (phase_q == 3'd0) || (phase_q == 3'd1) || (phase_q == 3'd3);
        pres_b = (phase_q == 3'd0) || (phase_q == 3'd2) || (phase_q == 3'd4);
      end
    endcase
  end

  // Frame control, symbol collection and pair assembly for the next cycle.
  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    valid_out_d = 1'b0;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    erase_a_d   = erase_a_q;
    erase_b_d   = erase_b_q;
    finished_d  = 1'b0;
    cnt_inc     = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

    if (enable) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            rate_d      = bus.rate;
            len_d       = bus.num_pairs;
            phase_d     = 3'd0;
            hold_d      = '0;
            hold_full_d = 1'b0;
            cnt_d       = '0;
            state_d     = (bus.num_pairs != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (bus.valid_in) begin
            if (pres_a && pres_b && !hold_full_q) begin
              hold_d      = bus.data_in;
              hold_full_d = 1'b1;
            end else begin
              valid_out_d = 1'b1;
              hold_full_d = 1'b0;
              if (pres_a && pres_b) begin
                data_a_d  = hold_q;
                data_b_d  = bus.data_in;
                erase_a_d = 1'b0;
                erase_b_d = 1'b0;
              end else if (pres_a) begin
                data_a_d  = bus.data_in;
                data_b_d  = '0;
                erase_a_d = 1'b0;
                erase_b_d = 1'b1;
              end else begin
                data_a_d  = '0;
                data_b_d  = bus.data_in;
                erase_a_d = 1'b1;
                erase_b_d = 1'b0;
              end
              phase_d = (phase_q == period - 3'd1) ? 3'd0 : phase_q + 3'd1;
              cnt_d   = cnt_inc;
              if (cnt_inc == len_q) begin
                state_d = DONE;
              end
            end
          end
        end
        DONE: begin
          finished_d = 1'b1;
          state_d    = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rate_q      <= 2'b00;
      len_q       <= '0;
      cnt_q       <= '0;
      phase_q     <= 3'd0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      valid_out_q <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      erase_a_q   <= 1'b0;
      erase_b_q   <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      valid_out_q <= valid_out_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      erase_a_q   <= erase_a_d;
      erase_b_q   <= erase_b_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
    end
  end

  assign bus.valid_out = valid_out_q;
  assign bus.data_a    = data_a_q;
  assign bus.data_b    = data_b_q;
  assign bus.erase_a   = erase_a_q;
  assign bus.erase_b   = erase_b_q;
  assign bus.busy      = busy_q;
  assign bus.finished  = finished_q;

endmodule

// File: tb/tb_depuncturer_multirate_wifi.sv
// Testbench for the multirate depuncturer: random and directed frames
// compared against a pattern-table reference model.
module tb_depuncturer_multirate_wifi;

  localparam int SOFT_W = 3;
  localparam int LEN_W  = 16;

  // Puncturing tables by rate code: pattern period and per-phase presence
  // masks (bit p set = branch transmitted in phase p).
  localparam int PER [4] = '{1, 2, 3, 5};
  localparam int PA  [4] = '{1, 3, 3, 11};
  localparam int PB  [4] = '{1, 1, 5, 21};

  typedef struct packed {
    logic [SOFT_W-1:0] a;
    logic [SOFT_W-1:0] b;
    logic              ea;
    logic              eb;
  } pair_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [SOFT_W-1:0] sym_q[$];
  pair_t             exp_q[$];
  int                pair_of[$];

  depuncturer_multirate_wifi_if #(.SOFT_W(SOFT_W), .LEN_W(LEN_W)) bus ();

  depuncturer_multirate_wifi #(.SOFT_W(SOFT_W), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic int count_syms(input int r, input int n);
    int total = 0;
    for (int k = 0; k < n; k++) begin
      total += PA[r][k % PER[r]] + PB[r][k % PER[r]];
    end
    return total;
  endfunction

  // Walk the pairs of the frame, consuming transmitted symbols in A-then-B order.
  function automatic void build_model(input int r, input int n);
    int idx = 0;
    exp_q.delete();
    pair_of.delete();
    foreach (sym_q[i]) pair_of.push_back(-1);
    for (int k = 0; k < n; k++) begin
      pair_t p;
      int ph = k % PER[r];
      p = '{a: '0, b: '0, ea: 1'b1, eb: 1'b1};
      if (PA[r][ph]) begin
        p.a = sym_q[idx];
        p.ea = 1'b0;
        idx++;
      end
      if (PB[r][ph]) begin
        p.b = sym_q[idx];
        p.eb = 1'b0;
        idx++;
      end
      pair_of[idx-1] = k;
      exp_q.push_back(p);
    end
  endfunction

  task automatic applyStimulus(input logic v, input logic [SOFT_W-1:0] d, input logic en);
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in  = d;
    enable       = en;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int r, input int n);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.rate      = 2'(r);
    bus.num_pairs = LEN_W'(n);
    bus.valid_in  = 1'b0;
    enable        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b, bus.busy, bus.finished} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got %b expected all zero",
               {bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b, bus.busy, bus.finished});
    end
  endtask

  // Full frame: optional random symbols and idle gaps, per-symbol latency check.
  task automatic test_frame(input int r, input int n, input bit gaps, input bit rnd, input string name);
    int last_k = -1;
    if (rnd) begin
      sym_q.delete();
      repeat (count_syms(r, n)) sym_q.push_back(SOFT_W'($urandom));
    end
    build_model(r, n);
    pulse_start(r, n);
    tests_run++;
    if (bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s busy_after_start got %b expected 1", name, bus.busy);
    end
    foreach (sym_q[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        applyStimulus(1'b0, SOFT_W'($urandom), 1'b1);
        tests_run++;
        if (bus.valid_out !== 1'b0 || (last_k >= 0 &&
            {bus.data_a, bus.data_b, bus.erase_a, bus.erase_b} !== exp_q[last_k])) begin
          tests_failed++;
          $display("[TB] FAIL %s gap_hold got v=%b %h expected v=0 held pair %0d", name,
                   bus.valid_out, {bus.data_a, bus.data_b, bus.erase_a, bus.erase_b}, last_k);
        end
      end
      applyStimulus(1'b1, sym_q[i], 1'b1);
      tests_run++;
      if (bus.valid_out !== (pair_of[i] >= 0)) begin
        tests_failed++;
        $display("[TB] FAIL %s valid_timing sym %0d got %b expected %b", name, i,
                 bus.valid_out, pair_of[i] >= 0);
      end else if (pair_of[i] >= 0) begin
        last_k = pair_of[i];
        tests_run++;
        if ({bus.data_a, bus.data_b, bus.erase_a, bus.erase_b} !== exp_q[last_k]) begin
          tests_failed++;
          $display("[TB] FAIL %s pair %0d got %h expected %h", name, last_k,
                   {bus.data_a, bus.data_b, bus.erase_a, bus.erase_b}, exp_q[last_k]);
        end
      end
      if (i < sym_q.size() - 1) begin
        tests_run++;
        if (bus.finished !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL %s early_finished sym %0d got 1 expected 0", name, i);
        end
      end
    end
    applyStimulus(1'b0, '0, 1'b1);
    tests_run++;
    if (bus.finished !== 1'b1 || bus.busy !== 1'b0 || bus.valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s finished_pulse got f=%b busy=%b v=%b expected f=1 busy=0 v=0",
               name, bus.finished, bus.busy, bus.valid_out);
    end
    applyStimulus(1'b0, '0, 1'b1);
    tests_run++;
    if (bus.finished !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s finished_width got 1 expected 0", name);
    end
  endtask

  task automatic test_rate_half_directed();
    int vals[8] = '{1, 2, 3, -1, -2, -3, 0, 1};
    sym_q.delete();
    foreach (vals[i]) sym_q.push_back(SOFT_W'(vals[i]));
    test_frame(0, 4, 1'b0, 1'b0, "rate12_directed");
  endtask

  task automatic test_rate_34_directed();
    int vals[4] = '{1, 2, 3, -4};
    sym_q.delete();
    foreach (vals[i]) sym_q.push_back(SOFT_W'(vals[i]));
    test_frame(2, 3, 1'b0, 1'b0, "rate34_directed");
  endtask

  // Enable low with a full hold register: input dropped, hold retained.
  task automatic test_enable_stall();
    pulse_start(1, 2);
    applyStimulus(1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, SOFT_W'($urandom), 1'b0);
      tests_run++;
      if (bus.valid_out !== 1'b0 || bus.busy !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stall_cycle %0d got v=%b busy=%b expected v=0 busy=1", i, bus.valid_out, bus.busy);
      end
    end
    applyStimulus(1'b1, 3'b101, 1'b1);
    tests_run++;
    if ({bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b} !== {1'b1, 3'd2, 3'b101, 2'b00}) begin
      tests_failed++;
      $display("[TB] FAIL stall_resume_pair got %b expected %b",
               {bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b}, {1'b1, 3'd2, 3'b101, 2'b00});
    end
    applyStimulus(1'b1, 3'd1, 1'b0);
    tests_run++;
    if (bus.valid_out !== 1'b0 || bus.data_a !== 3'd2) begin
      tests_failed++;
      $display("[TB] FAIL stall_strobe_clear got v=%b a=%h expected v=0 a=2", bus.valid_out, bus.data_a);
    end
    applyStimulus(1'b1, 3'd1, 1'b1);
    tests_run++;
    if ({bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b} !== {1'b1, 3'd1, 3'd0, 2'b01}) begin
      tests_failed++;
      $display("[TB] FAIL stall_second_pair got %b expected %b",
               {bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b}, {1'b1, 3'd1, 3'd0, 2'b01});
    end
    applyStimulus(1'b0, '0, 1'b1);
    tests_run++;
    if (bus.finished !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_finished got %b expected 1", bus.finished);
    end
    applyStimulus(1'b0, '0, 1'b1);
  endtask

  // Asynchronous reset in the middle of a 2/3 frame with the hold register full.
  task automatic test_reset_midframe();
    pulse_start(1, 4);
    applyStimulus(1'b1, 3'd1, 1'b1);
    applyStimulus(1'b1, 3'd2, 1'b1);
    applyStimulus(1'b1, 3'd3, 1'b1);
    applyStimulus(1'b1, 3'd1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b, bus.busy, bus.finished} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_midframe got %b expected all zero",
               {bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b, bus.busy, bus.finished});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      tests_run++;
      if (bus.finished !== 1'b0 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_no_finish cycle %0d got f=%b busy=%b expected 0 0", i, bus.finished, bus.busy);
      end
    end
    test_frame(1, 2, 1'b0, 1'b1, "after_reset");
  endtask

  task automatic test_zero_length();
    pulse_start(int'($urandom_range(0, 3)), 0);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.finished !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_len_cycle1 got busy=%b f=%b expected 0 0", bus.busy, bus.finished);
    end
    applyStimulus(1'b1, SOFT_W'($urandom), 1'b1);
    tests_run++;
    if (bus.finished !== 1'b1 || bus.valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_len_finished got f=%b v=%b expected f=1 v=0", bus.finished, bus.valid_out);
    end
    applyStimulus(1'b0, '0, 1'b1);
    tests_run++;
    if (bus.finished !== 1'b0 || bus.valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_len_after got f=%b v=%b expected 0 0", bus.finished, bus.valid_out);
    end
  endtask

  // A start pulse mid-frame must not change the rate or length in use.
  task automatic test_start_in_run();
    logic [SOFT_W-1:0] s[4];
    foreach (s[i]) s[i] = SOFT_W'($urandom);
    pulse_start(0, 2);
    bus.start     = 1'b1;
    bus.rate      = 2'b11;
    bus.num_pairs = LEN_W'(1);
    applyStimulus(1'b1, s[0], 1'b1);
    bus.start = 1'b0;
    applyStimulus(1'b1, s[1], 1'b1);
    tests_run++;
    if ({bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b, bus.finished} !== {1'b1, s[0], s[1], 3'b000}) begin
      tests_failed++;
      $display("[TB] FAIL start_in_run_pair0 got %b expected %b",
               {bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b, bus.finished}, {1'b1, s[0], s[1], 3'b000});
    end
    applyStimulus(1'b1, s[2], 1'b1);
    applyStimulus(1'b1, s[3], 1'b1);
    tests_run++;
    if ({bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b} !== {1'b1, s[2], s[3], 2'b00}) begin
      tests_failed++;
      $display("[TB] FAIL start_in_run_pair1 got %b expected %b",
               {bus.valid_out, bus.data_a, bus.data_b, bus.erase_a, bus.erase_b}, {1'b1, s[2], s[3], 2'b00});
    end
    applyStimulus(1'b0, '0, 1'b1);
    tests_run++;
    if (bus.finished !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_in_run_finished got %b expected 1", bus.finished);
    end
    applyStimulus(1'b0, '0, 1'b1);
  endtask

  task automatic test_idle_valid();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, SOFT_W'($urandom), 1'b1);
      tests_run++;
      if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL idle_valid cycle %0d got v=%b busy=%b expected 0 0", i, bus.valid_out, bus.busy);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int t = 0; t < 8; t++) begin
      test_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), 1'b1, 1'b1, "random_frame");
    end
  endtask

  initial begin
    reset         = 1'b0;
    enable        = 1'b0;
    bus.start     = 1'b0;
    bus.rate      = 2'b00;
    bus.num_pairs = '0;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_idle_valid();
    test_rate_half_directed();
    test_rate_34_directed();
    test_frame(3, 10, 1'b0, 1'b1, "rate56_continuous");
    test_enable_stall();
    test_reset_midframe();
    test_zero_length();
    test_start_in_run();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
